// File: rtl/cpu_mem_loader.sv
// Byte-serial loader that fills a data RAM and an instruction ROM, then runs an
// attached CPU until it reports idle, serving its instruction and data buses.
module cpu_mem_loader #(
  parameter int IMSB = 15,
  parameter int PMSB = 7,
  parameter int AMSB = 7,
  parameter int DMSB = 7
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_start,
  input  logic            i_ld_valid,
  input  logic [7:0]      i_ld_byte,
  output logic            o_ld_ready,
  output logic            o_setn,
  output logic            o_done,
  input  logic            i_sel,
  input  logic            i_write,
  input  logic            i_read,
  input  logic [AMSB:0]   i_addr,
  input  logic [DMSB:0]   i_wdata,
  output logic [DMSB:0]   o_rdata,
  input  logic [PMSB:0]   i_pc,
  output logic [IMSB:0]   o_inst,
  input  logic            i_cpu_idle
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_RAM,
    LOAD_ROM,
    HOLD,
    RUN,
    DONE
  } state_t;

  localparam logic [AMSB:0] RAM_LAST = '1;
  localparam logic [PMSB:0] ROM_LAST = '1;

  state_t         r_state;
  logic           r_ldReady;
  logic           r_setn;
  logic           r_done;
  logic [AMSB:0]  r_ramIdx;
  logic [PMSB:0]  r_romIdx;
  logic           r_romHi;
  logic           r_holdCnt;
  logic [1:0]     r_runCnt;
  logic [DMSB:0]  r_rdata;
  logic [IMSB:0]  r_inst;

  logic [DMSB:0]  r_ram [2**(AMSB+1)];
  logic [IMSB:0]  r_rom [2**(PMSB+1)];

  logic w_xfer;
  logic w_runDone;
  logic w_cpuWrite;
  logic w_unusedRead;

  assign w_xfer       = i_ld_valid & r_ldReady;
  assign w_runDone    = (r_state == RUN) && i_cpu_idle && (r_runCnt == 2'd2);
  assign w_cpuWrite   = (r_state == RUN) && i_sel && i_write;
  assign w_unusedRead = i_read;

  assign o_ld_ready = r_ldReady;
  assign o_setn     = r_setn;
  assign o_done     = r_done;
  assign o_rdata    = r_rdata;
  assign o_inst     = r_inst;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= IDLE;
      r_ldReady <= 1'b0;
      r_setn    <= 1'b0;
      r_done    <= 1'b0;
      r_ramIdx  <= '0;
      r_romIdx  <= '0;
      r_romHi   <= 1'b0;
      r_holdCnt <= 1'b0;
      r_runCnt  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state   <= LOAD_RAM;
            r_ldReady <= 1'b1;
            r_done    <= 1'b0;
            r_ramIdx  <= '0;
          end
        end
        LOAD_RAM: begin
          if (w_xfer) begin
            r_ramIdx <= r_ramIdx + 1'b1;
            if (r_ramIdx == RAM_LAST) begin
              r_state  <= LOAD_ROM;
              r_romIdx <= '0;
              r_romHi  <= 1'b0;
            end
          end
        end
        LOAD_ROM: begin
          if (w_xfer) begin
            r_romHi <= ~r_romHi;
            if (r_romHi) begin
              r_romIdx <= r_romIdx + 1'b1;
              if (r_romIdx == ROM_LAST) begin
                r_state   <= HOLD;
                r_ldReady <= 1'b0;
                r_holdCnt <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (r_holdCnt) begin
            r_state  <= RUN;
            r_setn   <= 1'b1;
            r_runCnt <= '0;
          end else begin
            r_holdCnt <= 1'b1;
          end
        end
        RUN: begin
          // The run counter saturates so the idle check is only armed from the third RUN cycle on.
          if (r_runCnt != 2'd2) begin
            r_runCnt <= r_runCnt + 2'd1;
          end
          if (w_runDone) begin
            r_state <= DONE;
            r_setn  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Instruction is zeroed on the edge leaving RUN so DONE never shows a stale opcode.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_inst  <= '0;
      r_rdata <= '0;
    end else begin
      if ((r_state == HOLD) || ((r_state == RUN) && !w_runDone)) begin
        r_inst <= r_rom[i_pc];
      end else begin
        r_inst <= '0;
      end
      if ((r_state == RUN) && i_sel) begin
        if (i_write) begin
          r_rdata <= i_wdata;
        end else begin
          r_rdata <= r_ram[i_addr];
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain so images survive an rstn pulse.
  always_ff @(posedge i_clk) begin
    if ((r_state == LOAD_RAM) && w_xfer) begin
      r_ram[r_ramIdx] <= i_ld_byte;
    end else if (w_cpuWrite) begin
      r_ram[i_addr] <= i_wdata;
    end
    if ((r_state == LOAD_ROM) && w_xfer) begin
      if (r_romHi) begin
        r_rom[r_romIdx][15:8] <= i_ld_byte;
      end else begin
        r_rom[r_romIdx][7:0] <= i_ld_byte;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader: load, hold, run, CPU bus traffic, done and
// mid-load reset abort, all against hand-computed values.
module tb_cpu_mem_loader;

  logic        clock;
  logic        rstn;
  logic        start;
  logic        ldValid;
  logic [7:0]  ldByte;
  logic        ldReady;
  logic        setn;
  logic        done;
  logic        sel;
  logic        write;
  logic        read;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [7:0]  pc;
  logic [15:0] inst;
  logic        cpuIdle;

  int checks;
  int errors;
  int xfers;
  int stalls;

  cpu_mem_loader dut (
    .i_clk      (clock),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_ld_valid (ldValid),
    .i_ld_byte  (ldByte),
    .o_ld_ready (ldReady),
    .o_setn     (setn),
    .o_done     (done),
    .i_sel      (sel),
    .i_write    (write),
    .i_read     (read),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .i_pc       (pc),
    .o_inst     (inst),
    .i_cpu_idle (cpuIdle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so a stuck DUT still ends the run with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] romWord(input int j);
    logic [7:0] jb;
    jb = j[7:0];
    if (j == 0) return 16'h8001;
    if (j == 1) return 16'h0000;
    return {~jb, jb};
  endfunction

  function automatic logic [7:0] imgByte(input int k, input int pat);
    logic [7:0]  kb;
    logic [15:0] w;
    int          r;
    if (k < 256) begin
      kb = k[7:0];
      case (pat)
        0:       return kb ^ 8'h5A;
        1:       return kb + 8'h33;
        default: return kb ^ 8'hC6;
      endcase
    end
    r = k - 256;
    w = romWord(r / 2);
    return (r % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] p);
    sel   = s;
    write = w;
    read  = s & ~w;
    addr  = a;
    wdata = d;
    pc    = p;
    @(posedge clock); #1;
  endtask

  // Feeds image bytes; a stall is any cycle where valid is offered but the DUT is not ready.
  task automatic loadImage(input int pat, input bit toggle, input int nBytes,
                           output int nXfer, output int nStall);
    int  idx;
    int  cyc;
    bit  v;
    bit  willXfer;
    idx    = 0;
    cyc    = 0;
    v      = 1'b1;
    nStall = 0;
    while (idx < nBytes && cyc < 4000) begin
      ldValid  = toggle ? v : 1'b1;
      ldByte   = imgByte(idx, pat);
      willXfer = ldValid && ldReady;
      if (ldValid && !ldReady) nStall++;
      @(posedge clock); #1;
      if (willXfer) idx++;
      v = ~v;
      cyc++;
    end
    ldValid = 1'b0;
    nXfer   = idx;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rstn    = 1'b0;
    start   = 1'b0;
    ldValid = 1'b0;
    ldByte  = '0;
    sel     = 1'b0;
    write   = 1'b0;
    read    = 1'b0;
    addr    = '0;
    wdata   = '0;
    pc      = '0;
    cpuIdle = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_ld_ready", ldReady, 0);
    checkOutput("rst_setn", setn, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_inst", inst, 0);
    rstn = 1'b1;
    @(posedge clock); #1;
    checkOutput("idle_ld_ready", ldReady, 0);

    $display("[TB] load with toggling valid");
    pulseStart();
    checkOutput("load_ready", ldReady, 1);
    loadImage(0, 1'b1, 768, xfers, stalls);
    checkOutput("load1_xfers", xfers, 768);
    checkOutput("load1_stalls", stalls, 0);

    ldValid = 1'b1;
    checkOutput("hold0_ready", ldReady, 0);
    checkOutput("hold0_setn", setn, 0);
    @(posedge clock); #1;
    checkOutput("hold1_ready", ldReady, 0);
    checkOutput("hold1_setn", setn, 0);
    @(posedge clock); #1;
    checkOutput("run_setn", setn, 1);
    checkOutput("run_ready", ldReady, 0);
    checkOutput("run_inst_pc0", inst, 16'h8001);
    ldValid = 1'b0;

    applyStimulus(0, 0, 8'h00, 8'h00, 8'h01);
    checkOutput("inst_pc1", inst, 16'h0000);
    applyStimulus(0, 0, 8'h00, 8'h00, 8'h05);
    checkOutput("inst_pc5", inst, 16'hFA05);
    applyStimulus(0, 0, 8'h00, 8'h00, 8'hFF);
    checkOutput("inst_pcFF", inst, 16'h00FF);

    applyStimulus(1, 0, 8'h10, 8'h00, 8'h00);
    checkOutput("rd_10", rdata, 8'h4A);
    applyStimulus(1, 0, 8'hFF, 8'h00, 8'h00);
    checkOutput("rd_FF", rdata, 8'hA5);
    applyStimulus(1, 0, 8'h00, 8'h00, 8'h00);
    checkOutput("rd_00", rdata, 8'h5A);
    applyStimulus(1, 1, 8'h20, 8'hC3, 8'h00);
    checkOutput("wr_20_through", rdata, 8'hC3);
    applyStimulus(1, 0, 8'h20, 8'h00, 8'h00);
    checkOutput("rd_20_after_wr", rdata, 8'hC3);
    applyStimulus(0, 1, 8'h21, 8'h77, 8'h00);
    checkOutput("nosel_hold", rdata, 8'hC3);
    applyStimulus(1, 0, 8'h21, 8'h00, 8'h00);
    checkOutput("rd_21_unwritten", rdata, 8'h7B);

    start = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
    start = 1'b0;
    checkOutput("start_in_run_setn", setn, 1);
    checkOutput("start_in_run_done", done, 0);
    checkOutput("start_in_run_ready", ldReady, 0);

    cpuIdle = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
    cpuIdle = 1'b0;
    checkOutput("done_done", done, 1);
    checkOutput("done_setn", setn, 0);
    checkOutput("done_inst", inst, 0);

    applyStimulus(1, 1, 8'h22, 8'h11, 8'h00);
    checkOutput("done_rdata_hold", rdata, 8'h7B);
    checkOutput("done_held", done, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);

    $display("[TB] restart then abort after 100 RAM bytes");
    pulseStart();
    checkOutput("restart_done_clr", done, 0);
    checkOutput("restart_ready", ldReady, 1);
    loadImage(1, 1'b0, 100, xfers, stalls);
    checkOutput("abort_xfers", xfers, 100);
    rstn = 1'b0;
    #1;
    checkOutput("abort_ready", ldReady, 0);
    checkOutput("abort_rdata", rdata, 0);
    checkOutput("abort_setn", setn, 0);
    @(posedge clock); #1;
    rstn = 1'b1;
    @(posedge clock); #1;

    pulseStart();
    loadImage(2, 1'b0, 768, xfers, stalls);
    checkOutput("load2_xfers", xfers, 768);
    checkOutput("load2_stalls", stalls, 0);
    cpuIdle = 1'b1;
    pc      = 8'h00;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("run2_setn", setn, 1);
    checkOutput("run2_inst", inst, 16'h8001);
    applyStimulus(1, 0, 8'h00, 8'h00, 8'h00);
    checkOutput("run2_rd_00", rdata, 8'hC6);
    checkOutput("run2_c1_setn", setn, 1);
    applyStimulus(1, 0, 8'h63, 8'h00, 8'h00);
    checkOutput("run2_rd_63", rdata, 8'hA5);
    checkOutput("run2_c2_done", done, 0);
    applyStimulus(1, 0, 8'hFF, 8'h00, 8'h00);
    checkOutput("run2_rd_FF", rdata, 8'h39);
    checkOutput("run2_c3_done", done, 1);
    checkOutput("run2_c3_setn", setn, 0);
    cpuIdle = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
